l1state_array: RTL
==================

# l1state_array

Parametrised L1 coherence-state array with one read port, one masked multi-way write port, write-first same-cycle bypass, and a built-in invalidation sweep that runs automatically after reset and on request. It sits beside the L1 tag/data arrays in the memory pipeline. It accepts mm1 requests and returns the per-set way states in mm2. The sweep removes any need for reset on the storage and lets the L1 flush all state without external sequencing.

## Interface
- NUM_SETS, 64, number of sets; power of two, at least 2.
- NUM_WAYS, 8, ways per set.
- STATE_W, 2, bits per way state; encoding matches t_mesi.
- INIT_STATE, 0, value written by the sweep; MESI Invalid.
- clk  in  1  clock; all logic is on the rising edge.
- reset_n  in  1  reset, asynchronous and active-low.
- init_req  in  1  one-cycle pulse that requests a full invalidation sweep.
- init_busy  out  1  high while the sweep is running; requesters must not issue rd/wr while it is high.
- rd_en_mm1  in  1  read request.
- rd_set_mm1  in  $clog2(NUM_SETS)  read set index.
- wr_en_mm1  in  1  write request.
- wr_set_mm1  in  $clog2(NUM_SETS)  write set index.
- wr_way_mask_mm1  in  NUM_WAYS  ways to write; one bit per way.
- wr_state_mm1  in  STATE_W  state written to every masked way.
- rd_ways_mm2  out  NUM_WAYS*STATE_W  states of all ways in the read set; way w is at bits [w*STATE_W +: STATE_W].
- rd_valid_mm2  out  1  rd_ways_mm2 carries a new read result.

## Operation
- Storage is NUM_SETS x NUM_WAYS x STATE_W flops. reset_n does not touch storage; the sweep initialises it.
- FSM has two states, SWEEP and IDLE.
  - Reset puts the FSM in SWEEP, sets the sweep counter to 0 and drives init_busy=1.
  - In SWEEP, each cycle writes INIT_STATE to every way of set[cnt], then increments cnt.
  - When cnt==NUM_SETS-1, that set is written and the next state is IDLE.
  - In IDLE, init_req=1 moves the FSM to SWEEP on the next cycle with cnt=0.
  - init_req while in SWEEP is ignored. The sweep does not restart.
- init_busy is high exactly when the FSM is in SWEEP.
- In SWEEP, rd_en_mm1 and wr_en_mm1 are dropped. No array update happens and rd_valid_mm2 stays 0.
- Write in IDLE: when wr_en_mm1=1, every way with its wr_way_mask_mm1 bit set in set wr_set_mm1 takes wr_state_mm1. A mask of all zeros is a no-op.
- Read in IDLE: when rd_en_mm1=1, the next cycle has rd_valid_mm2=1 and rd_ways_mm2 holding set rd_set_mm1.
- Bypass (write-first): when rd and wr target the same set in the same cycle, rd_ways_mm2 shows the post-write value for masked ways and the stored value for the other ways.
- When rd_en_mm1=0, rd_valid_mm2=0 next cycle and rd_ways_mm2 holds its last value.
- init_req in IDLE in the same cycle as rd/wr: the rd/wr is performed normally, and the sweep starts the next cycle.

## Timing
- Read latency is 1 cycle: mm1 request, mm2 data. Reads are fully pipelined, one per cycle.
- A write is visible to a read of the same set in the same cycle through the bypass, and to any read in a later cycle.
- Sweep length is NUM_SETS cycles.
  - After reset_n deasserts, init_busy is high for the first NUM_SETS rising edges.
  - After an init_req accepted at edge t, init_busy is high from t+1 through t+NUM_SETS.
- Reset values: init_busy=1, rd_valid_mm2=0, rd_ways_mm2=0, FSM=SWEEP, cnt=0.
- Reset asserted mid-sweep returns the FSM to SWEEP with cnt=0. The sweep then runs in full.
- Reset asserted while a read is in flight clears rd_valid_mm2 immediately (asynchronous).
- Assertions under ASSERT:
  - no rd_en_mm1 or wr_en_mm1 while init_busy=1;
  - wr_en_mm1=1 implies wr_way_mask_mm1 != 0 (warning only).

## Test plan
- Post-reset sweep: release reset_n with NUM_SETS=64 → init_busy stays 1 for 64 cycles then drops. A read of any set then returns all ways = 0 and rd_valid_mm2=1.
- Masked write then read: write set 5, mask 0b1000_0001, state E(2); read set 5 the next cycle → way0=2, way7=2, ways 1-6=0, valid one cycle after the read.
- Same-cycle bypass: with set 9 way3 = S(1), issue wr set 9 mask 0b1000 state M(3) and rd set 9 together → mm2 way3=3.
- Bypass isolation: wr set 9 and rd set 10 in the same cycle → read returns the old contents of set 10, and set 9 shows the update on a later read.
- Flush request: fill sets 0-3 with M, pulse init_req → init_busy high for 64 cycles. A pulse of init_req at cycle 10 of the sweep does not extend it. All sets read I afterwards. A rd/wr issued in the init_req cycle completes first.
- Reset mid-sweep: assert reset_n low at cycle 30 of a sweep and release it → a full 64-cycle sweep runs again, and rd_valid_mm2 and rd_ways_mm2 read 0 during reset.

Source files
------------

// File: rtl/l1state_array.sv
// L1 coherence-state array: one read port, masked multi-way write port,
// write-first bypass and a self-timed invalidation sweep.
module l1state_array #(
    parameter int                   NUM_SETS   = 64,
    parameter int                   NUM_WAYS   = 8,
    parameter int                   STATE_W    = 2,
    parameter logic [STATE_W-1:0]   INIT_STATE = '0,
    localparam int                  SET_W      = $clog2(NUM_SETS),
    localparam int                  ROW_W      = NUM_WAYS * STATE_W
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                init_req,
    output logic                init_busy,
    input  logic                rd_en_mm1,
    input  logic [SET_W-1:0]    rd_set_mm1,
    input  logic                wr_en_mm1,
    input  logic [SET_W-1:0]    wr_set_mm1,
    input  logic [NUM_WAYS-1:0] wr_way_mask_mm1,
    input  logic [STATE_W-1:0]  wr_state_mm1,
    output logic [ROW_W-1:0]    rd_ways_mm2,
    output logic                rd_valid_mm2
);

    typedef enum logic {SWEEP, IDLE} state_t;

    state_t             state, state_nxt;
    logic [SET_W-1:0]   cnt, cnt_nxt;
    logic [ROW_W-1:0]   mem [NUM_SETS];
    logic [ROW_W-1:0]   rd_row;
    logic               idle, rd_go, wr_go;

    assign idle      = (state == IDLE);
    assign init_busy = ~idle;
    assign rd_go     = rd_en_mm1 & idle;
    assign wr_go     = wr_en_mm1 & idle;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= SWEEP;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            SWEEP: begin
                cnt_nxt = cnt + 1'b1;
                if (cnt == SET_W'(NUM_SETS - 1)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            end
            IDLE: begin
                if (init_req) begin
                    state_nxt = SWEEP;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = SWEEP;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Storage is deliberately unreset; the sweep is its initialiser.
    always_ff @(posedge clk) begin
        if (!idle) begin
            mem[cnt] <= {NUM_WAYS{INIT_STATE}};
        end else if (wr_go) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (wr_way_mask_mm1[w])
                    mem[wr_set_mm1][w*STATE_W +: STATE_W] <= wr_state_mm1;
            end
        end
    end

    // Write-first: merge the same-cycle write into the read row.
    always_comb begin
        rd_row = mem[rd_set_mm1];
        if (wr_go && (wr_set_mm1 == rd_set_mm1)) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (wr_way_mask_mm1[w])
                    rd_row[w*STATE_W +: STATE_W] = wr_state_mm1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid_mm2 <= 1'b0;
            rd_ways_mm2  <= '0;
        end else begin
            rd_valid_mm2 <= rd_go;
            if (rd_go)
                rd_ways_mm2 <= rd_row;
        end
    end

`ifdef ASSERT
    always @(posedge clk) begin
        if (reset_n) begin
            assert (!(init_busy && (rd_en_mm1 || wr_en_mm1)))
                else $error("rd/wr issued while init_busy");
            if (wr_en_mm1)
                assert (wr_way_mask_mm1 != '0)
                    else $warning("write with empty way mask");
        end
    end
`endif

endmodule
